// File: rtl/divider_32bit.sv
// divider_32bit
// -----------------------------------------------------------------------------
// Multi-cycle restoring divider for the MIPS div/divu instructions. One
// quotient bit is resolved per clock by shift-and-trial-subtract; the final
// quotient and remainder are loaded into the output registers in a separate
// FINISH cycle, which feed the HI/LO registers.
//
// Optional feature: define DIVIDER_SIGNED_EN to add the isSigned port and
// two's-complement (MIPS div) semantics. Without it the block is unsigned only
// and no sign logic is built.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      one-cycle request, only sampled while idle
//   isSigned   signed division select (DIVIDER_SIGNED_EN builds only)
//   a, b       dividend / divisor, captured on the accepted start edge
//   quotient   result, held until the next operation's FINISH load
//   remainder  result, held until the next operation's FINISH load
//   busy       high from the edge after start until the result is loaded
//   done       one-cycle pulse when quotient/remainder are valid
//   divByZero  raised with done when b was zero; cleared by the next start
// -----------------------------------------------------------------------------
module divider_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef DIVIDER_SIGNED_EN
    input  logic             isSigned,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             divByZero
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FINISH
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_lat;      // original dividend, returned on divide-by-zero
    logic [WIDTH-1:0] divisor;    // divisor magnitude
    logic [WIDTH-1:0] q_sh;       // dividend shifts out the top, quotient bits in the bottom
    logic [WIDTH-1:0] rem;        // partial remainder
    logic [CW-1:0]    count;
    logic             b_zero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;   // quotient sign: operand signs differ
    logic neg_r;   // remainder follows the dividend's sign

    always_comb begin
        a_mag = (isSigned && a[WIDTH-1]) ? ('0 - a) : a;
        b_mag = (isSigned && b[WIDTH-1]) ? ('0 - b) : b;
    end
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // One restoring step: bring in the next dividend bit and try the
    // subtraction in WIDTH+1 bits so the borrow lands in the top bit.
    // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
    always_comb begin
        rem_shift = {rem[WIDTH-2:0], q_sh[WIDTH-1]};
        diff      = {1'b0, rem_shift} - {1'b0, divisor};
        rem_next  = rem_shift;
        q_next    = {q_sh[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            q_next   = {q_sh[WIDTH-2:0], 1'b1};
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (b == '0) ? FINISH : DIVIDE;
            DIVIDE:  if (count == LAST) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_lat     <= '0;
            divisor   <= '0;
            q_sh      <= '0;
            rem       <= '0;
            count     <= '0;
            b_zero    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            // Registered so busy rises on the edge after start and drops on
            // the same edge that raises done.
            busy <= (state == DIVIDE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat     <= a;
                        divisor   <= b_mag;
                        q_sh      <= a_mag;
                        rem       <= '0;
                        count     <= '0;
                        b_zero    <= (b == '0);
                        divByZero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                        neg_q     <= isSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r     <= isSigned & a[WIDTH-1];
`endif
                    end
                end
                DIVIDE: begin
                    rem   <= rem_next;
                    q_sh  <= q_next;
                    count <= count + CW'(1);
                end
                FINISH: begin
                    done <= 1'b1;
                    if (b_zero) begin
                        quotient  <= '1;
                        remainder <= a_lat;
                        divByZero <= 1'b1;
                    end else begin
`ifdef DIVIDER_SIGNED_EN
                        quotient  <= neg_q ? ('0 - q_sh) : q_sh;
                        remainder <= neg_r ? ('0 - rem) : rem;
`else
                        quotient  <= q_sh;
                        remainder <= rem;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32bit.sv
// tb_divider_32bit
// -----------------------------------------------------------------------------
// Self-checking bench for divider_32bit. Expected results come from plain
// integer division (with the MIPS divide-by-zero convention); timing of busy
// and done is checked cycle by cycle against the documented latency.
// Build with DIVIDER_SIGNED_EN defined to also exercise signed division.
// -----------------------------------------------------------------------------
module tb_divider_32bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        divByZero;
`ifdef DIVIDER_SIGNED_EN
    logic        is_signed_tb;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divider_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef DIVIDER_SIGNED_EN
        .isSigned  (is_signed_tb),
`endif
        .a         (a),
        .b         (b),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and park on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: integer division, truncating toward zero when signed,
    // remainder carrying the dividend's sign; b==0 returns all-ones / a.
    task automatic model(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (bv == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = av;
        end else if (sv) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = av / bv;
            r = av % bv;
        end
    endtask

    // Present a request and let one rising edge accept it.
    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        a = av;
        b = bv;
`ifdef DIVIDER_SIGNED_EN
        is_signed_tb = sv;
`else
        if (sv) $display("signed request dropped: DIVIDER_SIGNED_EN not defined");
`endif
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called just after launch; walks to the done cycle checking busy/done
    // every cycle, optionally re-pulsing start at cycle poke_at.
    task automatic expect_result(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                 input logic sv, input int poke_at);
        logic [31:0] eq, er;
        int lat;
        logic early_done, busy_bad;
        model(av, bv, sv, eq, er);
        lat        = (bv == 32'd0) ? 1 : 33;
        early_done = 1'b0;
        busy_bad   = 1'b0;
        check({tag, "_dbz_cleared"}, {31'd0, divByZero}, 32'd0);
        for (int i = 1; i < lat; i++) begin
            if (i == poke_at) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end
            step();
            start = 1'b0;
            if (done !== 1'b0) early_done = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
        end
        step();
        check({tag, "_early_done"}, {31'd0, early_done}, 32'd0);
        check({tag, "_busy_window"}, {31'd0, busy_bad}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_divByZero"}, {31'd0, divByZero}, {31'd0, bv == 32'd0});
    endtask

    // One cycle after done: pulse over, results held.
    task automatic expect_hold(input string tag, input logic [31:0] eq, input logic [31:0] er);
        step();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_q_hold"}, quotient, eq);
        check({tag, "_r_hold"}, remainder, er);
    endtask

    initial begin
        logic [31:0] ra, rb, eq, er;
        logic        rs;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef DIVIDER_SIGNED_EN
        is_signed_tb = 1'b0;
`endif
        repeat (3) step();
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, divByZero}, 32'd0);
        reset = 1'b0;
        step();

        // Basic unsigned division.
        launch(32'd100, 32'd7, 1'b0);
        expect_result("u100_7", 32'd100, 32'd7, 1'b0, 0);
        expect_hold("u100_7", 32'd14, 32'd2);

        // Largest dividend, then a back-to-back start in the done cycle.
        launch(32'hFFFF_FFFF, 32'd1, 1'b0);
        expect_result("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        launch(32'd5, 32'd10, 1'b0);
        check("b2b_q_held", quotient, 32'hFFFF_FFFF);
        expect_result("b2b_5_10", 32'd5, 32'd10, 1'b0, 0);
        expect_hold("b2b_5_10", 32'd0, 32'd5);

        // Divide by zero: one-cycle latency.
        launch(32'h1234_5678, 32'd0, 1'b0);
        expect_result("dbz", 32'h1234_5678, 32'd0, 1'b0, 0);
        expect_hold("dbz", 32'hFFFF_FFFF, 32'h1234_5678);
        check("dbz_flag_held", {31'd0, divByZero}, 32'd1);

        // Start pulsed at cycle 5 while busy is ignored.
        launch(32'd1_000_000, 32'd999, 1'b0);
        expect_result("busy_start", 32'd1_000_000, 32'd999, 1'b0, 5);

        // Reset ten cycles into a division.
        launch(32'hDEAD_BEEF, 32'd3, 1'b0);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        launch(32'hDEAD_BEEF, 32'd3, 1'b0);
        expect_result("after_rst", 32'hDEAD_BEEF, 32'd3, 1'b0, 0);

`ifdef DIVIDER_SIGNED_EN
        launch(32'hFFFF_FFF9, 32'd2, 1'b1);
        expect_result("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        check("s_m7_2_q_const", quotient, 32'hFFFF_FFFD);
        check("s_m7_2_r_const", remainder, 32'hFFFF_FFFF);
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        expect_result("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        check("s_ovf_q_const", quotient, 32'h8000_0000);
        check("s_ovf_r_const", remainder, 32'd0);
        launch(32'h8000_0000, 32'd0, 1'b1);
        expect_result("s_dbz", 32'h8000_0000, 32'd0, 1'b1, 0);
`endif

        // Randomised operands; divisor width varied so quotients span widths.
        for (int n = 0; n < 12; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
`ifdef DIVIDER_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            model(ra, rb, rs, eq, er);
            launch(ra, rb, rs);
            expect_result($sformatf("rand%0d", n), ra, rb, rs, 0);
            expect_hold($sformatf("rand%0d", n), eq, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/divider_32bit.md
# divider_32bit

Multi-cycle 32-bit restoring divider for the MIPS datapath's div/divu instructions. It performs division by repeated subtract-and-shift, the inverse of the 32-bit adder, and produces the quotient and remainder that the HI/LO registers load. It sits beside the ALU and is controlled by the multi-cycle control unit through a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 32, operand, quotient and remainder width. Only 32 is verified.

Ports:
- clk  input  1  rising-edge clock; the block uses only this clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- isSigned  input  1  selects signed division; present only when DIVIDER_SIGNED_EN is defined.
- a  input  WIDTH  dividend; sampled on the start edge.
- b  input  WIDTH  divisor; sampled on the start edge.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- busy  output  1  high while an operation is in progress, from the edge after start until done.
- done  output  1  one-cycle pulse when the results are valid.
- divByZero  output  1  set with done when b==0; held with the results.

## Operation
- FSM states: IDLE, DIVIDE, FINISH.
  - IDLE: when start=1, latch a, b and isSigned.
    - If b==0, go to FINISH.
    - Otherwise clear the partial remainder, load the dividend magnitude into the quotient shift register, set the count to 0, and go to DIVIDE.
  - DIVIDE: one iteration per cycle.
    - rem' = {rem[30:0], q[31]}.
    - diff = {1'b0, rem'} − {1'b0, divisor} (33 bits).
    - If diff[32]==0: rem = diff[31:0] and shift 1 into q. Otherwise rem = rem' and shift 0 into q.
    - After the 32nd iteration (count==31), go to FINISH.
  - FINISH: load the quotient and remainder outputs, pulse done, and return to IDLE.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = a, divByZero = 1. This holds in both signed and unsigned modes.
- Unsigned arithmetic: all values are treated as unsigned 32-bit magnitudes. Quotient and remainder satisfy a = q·b + r with r < b.
- A start received while busy=1 is ignored. The operation in progress is unaffected.
- Reset, including during DIVIDE: state returns to IDLE and all internal registers clear. Outputs go to quotient=0, remainder=0, busy=0, done=0, divByZero=0.
- divByZero clears on the next accepted start.

## Timing
- Start accepted on edge k, b≠0:
  - busy=1 for cycles k+1 through k+32.
  - done=1 and results valid during the cycle after edge k+33. Latency is 33 cycles.
  - busy=0 while done=1.
- Start accepted on edge k, b==0: done=1 during the cycle after edge k+1. Latency is 1 cycle.
- done lasts exactly one cycle. Outputs are stable from the done cycle until the FINISH load of the next operation.
- Back-to-back: a start asserted in the done cycle is accepted, because the FSM is then in IDLE.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - The isSigned port exists. When isSigned=1, the divider operates on |a| and |b|.
  - The quotient is negated when a[31]^b[31]. The remainder takes the sign of a, matching MIPS div.
  - Sign fix-up happens in the FINISH load, so latency is unchanged.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
- DIVIDER_SIGNED_EN not defined: there is no isSigned port, all operations are unsigned, and the sign logic is not synthesized.

## Test plan
- Reset applied mid-DIVIDE (cycle 10 after start) -> next cycle busy=0, done=0, quotient=0, remainder=0. A new start then runs the full 33 cycles.
- Unsigned a=100, b=7 -> done 33 cycles after the start edge; quotient=14, remainder=2, divByZero=0.
- a=0xFFFFFFFF, b=1, followed by a start issued in the done cycle with a=5, b=10 -> first result quotient=0xFFFFFFFF, remainder=0; second result quotient=0, remainder=5.
- b=0, a=0x12345678 -> done 1 cycle after start; quotient=0xFFFFFFFF, remainder=0x12345678, divByZero=1.
- Start pulsed again at cycle 5 of a busy operation -> ignored; the original result still arrives on time.
- DIVIDER_SIGNED_EN, isSigned=1:
  - a=−7, b=2 -> quotient=−3 (0xFFFFFFFD), remainder=−1 (0xFFFFFFFF).
  - a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
